// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display path: anode one-hot codes,
// blank segment pattern, segment bit order and digit index encoding.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_R  = 4'b1110;
  localparam logic [3:0] AN_RC = 4'b1101;
  localparam logic [3:0] AN_LC = 4'b1011;
  localparam logic [3:0] AN_L  = 4'b0111;

  // Bit positions within the active-low segment vector {g,f,e,d,c,b,a}
  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  typedef enum logic [1:0] {
    DIGIT_R  = 2'd0,
    DIGIT_RC = 2'd1,
    DIGIT_LC = 2'd2,
    DIGIT_L  = 2'd3
  } digit_e;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (nibble)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_digit_driver.sv
// Cathode driver: double-buffered hex value committed at scan-frame start,
// leading-zero blanking and per-digit decimal points for the lit digit.
module seven_seg_digit_driver
  import seven_seg_pkg::*;
#(
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        load,
  output logic        pending,
  output logic        frame_done,
  output logic [6:0]  seg_n,
  output logic        dp_n
);

  logic [3:0]  anode_s1, anode_s2;
  logic [15:0] staging_value, shadow_value;
  logic [3:0]  staging_dp, shadow_dp;
  logic        boundary, commit;
  digit_e      digit;
  logic        digit_valid, digit_blank, dp_sel, dp_next;
  logic [3:0]  nibble;
  logic [6:0]  decoded, seg_next;

  // Frame starts on the first synchronised cycle that digit R is lit
  assign boundary = (anode_s1 == AN_R) && (anode_s2 != AN_R);
  assign commit   = boundary && pending;

  always_comb begin
    digit       = DIGIT_R;
    digit_valid = 1'b1;
    case (anode_s2)
      AN_R:    digit = DIGIT_R;
      AN_RC:   digit = DIGIT_RC;
      AN_LC:   digit = DIGIT_LC;
      AN_L:    digit = DIGIT_L;
      default: digit_valid = 1'b0;
    endcase
  end

  always_comb begin
    nibble      = shadow_value[3:0];
    dp_sel      = shadow_dp[0];
    digit_blank = 1'b0;
    case (digit)
      DIGIT_R: begin
        nibble = shadow_value[3:0];
        dp_sel = shadow_dp[0];
      end
      DIGIT_RC: begin
        nibble      = shadow_value[7:4];
        dp_sel      = shadow_dp[1];
        digit_blank = BLANK_LEADING && (shadow_value[15:4] == '0);
      end
      DIGIT_LC: begin
        nibble      = shadow_value[11:8];
        dp_sel      = shadow_dp[2];
        digit_blank = BLANK_LEADING && (shadow_value[15:8] == '0);
      end
      DIGIT_L: begin
        nibble      = shadow_value[15:12];
        dp_sel      = shadow_dp[3];
        digit_blank = BLANK_LEADING && (shadow_value[15:12] == '0);
      end
      default: ;
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg_n  (decoded)
  );

  // Blanked digits still show their decimal point
  assign seg_next = (!digit_valid || digit_blank) ? SEG_BLANK : decoded;
  assign dp_next  = digit_valid ? ~dp_sel : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode_s1      <= '1;
      anode_s2      <= '1;
      staging_value <= '0;
      staging_dp    <= '0;
      shadow_value  <= '0;
      shadow_dp     <= '0;
      pending       <= 1'b0;
      frame_done    <= 1'b0;
      seg_n         <= SEG_BLANK;
      dp_n          <= 1'b1;
    end else begin
      anode_s1   <= anode;
      anode_s2   <= anode_s1;
      frame_done <= commit;
      seg_n      <= seg_next;
      dp_n       <= dp_next;
      if (commit) begin
        shadow_value <= staging_value;
        shadow_dp    <= staging_dp;
      end
      // A coincident load restages after the old staging was committed
      if (load) begin
        staging_value <= value;
        staging_dp    <= dp;
        pending       <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
